// File: rtl/serial_mouse.sv
`default_nettype none
// ============================================================================
//  Module   : serial_mouse
//  Purpose  : Microsoft-compatible serial mouse emulator. Accumulates relative
//             motion and button reports and transmits 3-byte 7N1 packets at
//             BAUD toward the UART rx pin. The mouse is powered and held in
//             reset by RTS (active low). It announces itself with 'M' each
//             time RTS is asserted.
//  Optional : define SERIAL_MOUSE_MIDBTN_EN for Logitech 3-button mode. This
//             sends the ID "M3", lets btn_m trigger packets, and appends a
//             4th byte (0x20 when pressed) when the middle button is pressed
//             or has changed.
//  Ports    : clk, reset        - clock, synchronous active-high reset
//             rts_n             - low = powered; high = held in reset
//             dtr_n             - unused, kept for wiring symmetry
//             mouse_valid       - one-cycle strobe for dx/dy/buttons
//             mouse_dx/mouse_dy - 9-bit signed deltas (dy positive = down)
//             btn_l/btn_r/btn_m - button levels
//             tx                - serial line, idle high
//             busy              - high during start/data/stop bits
//  Revision : 1.0 - initial release
// ============================================================================
module serial_mouse #(
  parameter int CLK_FREQ = 50000000,
  parameter int BAUD     = 1200
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rts_n,
  input  logic       dtr_n,
  input  logic       mouse_valid,
  input  logic [8:0] mouse_dx,
  input  logic [8:0] mouse_dy,
  input  logic       btn_l,
  input  logic       btn_r,
  input  logic       btn_m,
  output logic       tx,
  output logic       busy
);
  localparam int CLK_DIV = CLK_FREQ / BAUD;
  localparam int CNT_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);

  // Byte (line) FSM
  localparam logic [1:0] B_IDLE  = 2'd0;
  localparam logic [1:0] B_START = 2'd1;
  localparam logic [1:0] B_DATA  = 2'd2;
  localparam logic [1:0] B_STOP  = 2'd3;

  // Packet FSM; P_WAIT/P_ID/P_Bn name the byte that is next to be launched
  localparam logic [2:0] P_OFF  = 3'd0;
  localparam logic [2:0] P_WAIT = 3'd1;
  localparam logic [2:0] P_ID   = 3'd2;
  localparam logic [2:0] P_IDLE = 3'd3;
  localparam logic [2:0] P_B1   = 3'd4;
  localparam logic [2:0] P_B2   = 3'd5;
  localparam logic [2:0] P_B3   = 3'd6;
  localparam logic [2:0] P_B4   = 3'd7;

  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [1:0]         bst_q, bst_d;
  logic [2:0]         bit_q, bit_d;
  logic [6:0]         shr_q, shr_d;
  logic               tx_q, tx_d;
  logic [2:0]         pst_q, pst_d;
  logic signed [11:0] acc_x_q, acc_x_d, acc_y_q, acc_y_d;
  logic signed [7:0]  sx_q, sx_d, sy_q, sy_d;
  logic               btn_l_q, btn_l_d, btn_r_q, btn_r_d;
  logic               sent_l_q, sent_l_d, sent_r_q, sent_r_d;
`ifdef SERIAL_MOUSE_MIDBTN_EN
  logic               btn_m_q, btn_m_d, sent_m_q, sent_m_d, b4_q, b4_d;
`endif

  logic               tick, launch, have_byte, snap, trigger;
  logic [6:0]         next_byte;
  logic signed [7:0]  sx_snap, sy_snap, sub_x, sub_y;
  logic [8:0]         dlt_x, dlt_y;
  logic signed [13:0] sum_x, sum_y;

  logic unused_inputs;
  assign unused_inputs = &{1'b0, dtr_n, btn_m};

  function automatic logic signed [11:0] sat12(input logic signed [13:0] v);
    if (v > 14'sd2047)       return 12'sh7FF;
    else if (v < -14'sd2048) return 12'sh800;
    else                     return v[11:0];
  endfunction

  function automatic logic signed [7:0] clamp8(input logic signed [11:0] v);
    if (v > 12'sd127)       return 8'sh7F;
    else if (v < -12'sd128) return 8'sh80;
    else                    return v[7:0];
  endfunction

  always_comb begin
    tick      = (cnt_q == CNT_MAX);
    sx_snap   = clamp8(acc_x_q);
    sy_snap   = clamp8(acc_y_q);

    // Byte offered to the line by the packet FSM
    have_byte = 1'b0;
    next_byte = 7'h00;
    case (pst_q)
      P_WAIT: begin have_byte = 1'b1; next_byte = 7'h4D; end
`ifdef SERIAL_MOUSE_MIDBTN_EN
      P_ID:   begin have_byte = 1'b1; next_byte = 7'h33; end
      P_B4:   begin have_byte = 1'b1; next_byte = sent_m_q ? 7'h20 : 7'h00; end
`endif
      P_B1:   begin
        have_byte = 1'b1;
        next_byte = {1'b1, sent_l_q, sent_r_q, sy_q[7:6], sx_q[7:6]};
      end
      P_B2:   begin have_byte = 1'b1; next_byte = {1'b0, sx_q[5:0]}; end
      P_B3:   begin have_byte = 1'b1; next_byte = {1'b0, sy_q[5:0]}; end
      default: ;
    endcase

    // A frame starts only on a tick while the line is idle or finishing a
    // stop bit, which makes consecutive bytes of a packet gap-free.
    launch = tick && have_byte && (bst_q == B_IDLE || bst_q == B_STOP);

    trigger = (acc_x_q != 12'sd0) || (acc_y_q != 12'sd0) ||
              (btn_l_q != sent_l_q) || (btn_r_q != sent_r_q);
`ifdef SERIAL_MOUSE_MIDBTN_EN
    trigger = trigger || (btn_m_q != sent_m_q);
`endif

    // Packet FSM
    pst_d = pst_q;
    snap  = 1'b0;
    case (pst_q)
      P_OFF:  pst_d = P_WAIT;
      P_WAIT: if (launch) pst_d = P_ID;
`ifdef SERIAL_MOUSE_MIDBTN_EN
      P_ID:   if (launch) pst_d = P_IDLE;
`else
      P_ID:   pst_d = P_IDLE;
`endif
      // Waiting for the line to go idle leaves a bit-time gap between packets
      P_IDLE: if (bst_q == B_IDLE && trigger) begin
        pst_d = P_B1;
        snap  = 1'b1;
      end
      P_B1:   if (launch) pst_d = P_B2;
      P_B2:   if (launch) pst_d = P_B3;
`ifdef SERIAL_MOUSE_MIDBTN_EN
      P_B3:   if (launch) pst_d = b4_q ? P_B4 : P_IDLE;
      P_B4:   if (launch) pst_d = P_IDLE;
`else
      P_B3:   if (launch) pst_d = P_IDLE;
      P_B4:   pst_d = P_IDLE;
`endif
      default: pst_d = P_IDLE;
    endcase

    // Bit timer restarts when RTS is first seen asserted
    if (pst_q == P_OFF || tick) cnt_d = '0;
    else                        cnt_d = cnt_q + 1'b1;

    // Byte FSM
    bst_d = bst_q;
    bit_d = bit_q;
    shr_d = shr_q;
    if (tick) begin
      case (bst_q)
        B_START: begin bst_d = B_DATA; bit_d = 3'd0; end
        B_DATA:  begin
          if (bit_q == 3'd6) bst_d = B_STOP;
          else begin
            bit_d = bit_q + 3'd1;
            shr_d = shr_q >> 1;
          end
        end
        default: begin
          if (launch) begin bst_d = B_START; shr_d = next_byte; end
          else        bst_d = B_IDLE;
        end
      endcase
    end
    case (bst_d)
      B_START: tx_d = 1'b0;
      B_DATA:  tx_d = shr_d[0];
      default: tx_d = 1'b1;
    endcase

    // Accumulators: the snapshot is subtracted and a same-cycle delta added
    // in one step so no motion is lost.
    sub_x = snap ? sx_snap : 8'sd0;
    sub_y = snap ? sy_snap : 8'sd0;
    dlt_x = mouse_valid ? mouse_dx : 9'd0;
    dlt_y = mouse_valid ? mouse_dy : 9'd0;
    sum_x = {{2{acc_x_q[11]}}, acc_x_q} - {{6{sub_x[7]}}, sub_x} + {{5{dlt_x[8]}}, dlt_x};
    sum_y = {{2{acc_y_q[11]}}, acc_y_q} - {{6{sub_y[7]}}, sub_y} + {{5{dlt_y[8]}}, dlt_y};
    acc_x_d = sat12(sum_x);
    acc_y_d = sat12(sum_y);

    btn_l_d  = mouse_valid ? btn_l : btn_l_q;
    btn_r_d  = mouse_valid ? btn_r : btn_r_q;
    sent_l_d = snap ? btn_l_q : sent_l_q;
    sent_r_d = snap ? btn_r_q : sent_r_q;
    sx_d     = snap ? sx_snap : sx_q;
    sy_d     = snap ? sy_snap : sy_q;
`ifdef SERIAL_MOUSE_MIDBTN_EN
    btn_m_d  = mouse_valid ? btn_m : btn_m_q;
    sent_m_d = snap ? btn_m_q : sent_m_q;
    // B4 goes out when M is pressed now or was pressed in the last packet
    b4_d     = snap ? (btn_m_q | sent_m_q) : b4_q;
`endif
  end

  // RTS deasserted acts exactly like reset: the line is released on the next edge
  always_ff @(posedge clk) begin
    if (reset || rts_n) begin
      cnt_q    <= '0;
      bst_q    <= B_IDLE;
      bit_q    <= 3'd0;
      shr_q    <= 7'h00;
      tx_q     <= 1'b1;
      pst_q    <= P_OFF;
      acc_x_q  <= 12'sd0;
      acc_y_q  <= 12'sd0;
      sx_q     <= 8'sd0;
      sy_q     <= 8'sd0;
      btn_l_q  <= 1'b0;
      btn_r_q  <= 1'b0;
      sent_l_q <= 1'b0;
      sent_r_q <= 1'b0;
`ifdef SERIAL_MOUSE_MIDBTN_EN
      btn_m_q  <= 1'b0;
      sent_m_q <= 1'b0;
      b4_q     <= 1'b0;
`endif
    end else begin
      cnt_q    <= cnt_d;
      bst_q    <= bst_d;
      bit_q    <= bit_d;
      shr_q    <= shr_d;
      tx_q     <= tx_d;
      pst_q    <= pst_d;
      acc_x_q  <= acc_x_d;
      acc_y_q  <= acc_y_d;
      sx_q     <= sx_d;
      sy_q     <= sy_d;
      btn_l_q  <= btn_l_d;
      btn_r_q  <= btn_r_d;
      sent_l_q <= sent_l_d;
      sent_r_q <= sent_r_d;
`ifdef SERIAL_MOUSE_MIDBTN_EN
      btn_m_q  <= btn_m_d;
      sent_m_q <= sent_m_d;
      b4_q     <= b4_d;
`endif
    end
  end

  assign tx   = tx_q;
  assign busy = (bst_q != B_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_serial_mouse.sv
`default_nettype none
// ============================================================================
//  Module   : tb_serial_mouse
//  Purpose  : Directed self-checking bench for serial_mouse at CLK_DIV=16.
//             Decodes the tx line and compares against hand-computed bytes.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_serial_mouse;
  logic       clk = 1'b0;
  logic       reset, rts_n, dtr_n, mouse_valid;
  logic [8:0] mouse_dx, mouse_dy;
  logic       btn_l, btn_r, btn_m;
  logic       tx, busy;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  serial_mouse #(.CLK_FREQ(19200), .BAUD(1200)) dut (
    .clk(clk), .reset(reset), .rts_n(rts_n), .dtr_n(dtr_n),
    .mouse_valid(mouse_valid), .mouse_dx(mouse_dx), .mouse_dy(mouse_dy),
    .btn_l(btn_l), .btn_r(btn_r), .btn_m(btn_m), .tx(tx), .busy(busy)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mouse_pulse(input int dx, input int dy, input logic l, input logic r, input logic m);
    mouse_dx = 9'(dx);
    mouse_dy = 9'(dy);
    btn_l = l; btn_r = r; btn_m = m;
    mouse_valid = 1'b1;
    step();
    mouse_valid = 1'b0;
  endtask

  // Receives one 7N1 frame; returns at the middle of the stop bit.
  task automatic rx_byte(input string tag, output logic [6:0] b, output int t0);
    int w;
    logic [8:0] fr;
    w = 0;
    b = 7'h00;
    t0 = -1;
    while (tx !== 1'b0 && w < 3000) begin
      step();
      w++;
    end
    if (tx !== 1'b0) begin
      check({tag, "_start_timeout"}, int'(tx), 0);
      return;
    end
    t0 = cyc;
    repeat (8) step();
    fr[0] = tx;
    for (int k = 1; k < 9; k++) begin
      repeat (16) step();
      fr[k] = tx;
    end
    check({tag, "_startbit"}, int'(fr[0]), 0);
    check({tag, "_stopbit"}, int'(fr[8]), 1);
    b = fr[7:1];
  endtask

  task automatic rx_packet(input string tag, input int n,
                           input logic [6:0] e0, input logic [6:0] e1,
                           input logic [6:0] e2, input logic [6:0] e3);
    logic [6:0] exp_b [4];
    logic [6:0] b;
    int t0, tfirst;
    exp_b[0] = e0; exp_b[1] = e1; exp_b[2] = e2; exp_b[3] = e3;
    tfirst = 0;
    for (int i = 0; i < n; i++) begin
      rx_byte($sformatf("%s_b%0d", tag, i + 1), b, t0);
      if (i == 0) tfirst = t0;
      check($sformatf("%s_b%0d", tag, i + 1), int'(b), int'(exp_b[i]));
      if (i > 0) check($sformatf("%s_spacing%0d", tag, i), t0 - tfirst, 144 * i);
    end
  endtask

  // Called from mid-stop of a last byte (or late in it): line must stay idle.
  task automatic expect_quiet(input string tag, input int n);
    int act;
    act = 0;
    repeat (8) step();
    for (int i = 0; i < n; i++) begin
      step();
      if (tx !== 1'b1 || busy !== 1'b0) act++;
    end
    check(tag, act, 0);
  endtask

  task automatic power_cycle(input string tag);
    int tx_err, busy_err;
    logic [8:0] id_frame;
    logic exp_tx;
    logic [6:0] b;
    int t0;
    tx_err = 0;
    busy_err = 0;
    id_frame = {1'b1, 7'h4D, 1'b0};
    rts_n = 1'b1;
    repeat (4) step();
    check({tag, "_off_tx"}, int'(tx), 1);
    check({tag, "_off_busy"}, int'(busy), 0);
    rts_n = 1'b0;
    for (int n = 0; n < 160; n++) begin
      step();
      exp_tx = (n < 16) ? 1'b1 : id_frame[(n - 16) / 16];
      if (tx !== exp_tx) tx_err++;
      if (busy !== (n >= 16)) busy_err++;
    end
    check({tag, "_id_wave"}, tx_err, 0);
    check({tag, "_id_busy"}, busy_err, 0);
`ifdef SERIAL_MOUSE_MIDBTN_EN
    rx_byte({tag, "_id2"}, b, t0);
    check({tag, "_id2"}, int'(b), 'h33);
`else
    b = 7'h00;
    t0 = 0;
`endif
  endtask

  initial begin
    logic [6:0] b;
    int t0;
    reset = 1'b1; rts_n = 1'b1; dtr_n = 1'b1; mouse_valid = 1'b0;
    mouse_dx = '0; mouse_dy = '0; btn_l = 1'b0; btn_r = 1'b0; btn_m = 1'b0;
    repeat (5) step();
    check("reset_tx", int'(tx), 1);
    check("reset_busy", int'(busy), 0);
    reset = 1'b0;

    // ID on power-up
    power_cycle("pwr1");

    // Basic packet: dx=+5, dy=-3, left pressed
    mouse_pulse(5, -3, 1'b1, 1'b0, 1'b0);
    rx_packet("basic", 3, 7'h6C, 7'h05, 7'h3D, 7'h00);
    expect_quiet("basic_quiet", 400);

    // Button-only release packet
    mouse_pulse(0, 0, 1'b0, 1'b0, 1'b0);
    rx_packet("release", 3, 7'h40, 7'h00, 7'h00, 7'h00);
    expect_quiet("release_quiet", 400);

    // Saturation and drain: 255 -> 127, 127, 1
    mouse_pulse(255, 0, 1'b0, 1'b0, 1'b0);
    rx_packet("sat1", 3, 7'h41, 7'h3F, 7'h00, 7'h00);
    repeat (9) step();
    check("sat_gap_busy", int'(busy), 0);
    rx_packet("sat2", 3, 7'h41, 7'h3F, 7'h00, 7'h00);
    rx_packet("sat3", 3, 7'h40, 7'h01, 7'h00, 7'h00);
    expect_quiet("sat_quiet", 400);

    // Simultaneous event: acc_x=200, then +10 on the snapshot cycle
    mouse_pulse(200, 0, 1'b0, 1'b0, 1'b0);
    mouse_pulse(10, 0, 1'b0, 1'b0, 1'b0);
    rx_packet("simul1", 3, 7'h41, 7'h3F, 7'h00, 7'h00);
    rx_packet("simul2", 3, 7'h41, 7'h13, 7'h00, 7'h00);
    expect_quiet("simul_quiet", 400);

    // Abort during DATA3 of B2 (B2 = 0x20, so bit 3 is a zero on the line)
    mouse_pulse(32, 0, 1'b0, 1'b0, 1'b0);
    rx_byte("abort_b1", b, t0);
    check("abort_b1", int'(b), 'h40);
    mouse_pulse(40, 0, 1'b0, 1'b0, 1'b0);
    while (cyc < t0 + 144 + 64 + 4) step();
    check("abort_pre_tx", int'(tx), 0);
    rts_n = 1'b1;
    step();
    check("abort_tx", int'(tx), 1);
    check("abort_busy", int'(busy), 0);
    power_cycle("pwr2");
    expect_quiet("abort_no_motion", 400);

    // Middle button
`ifdef SERIAL_MOUSE_MIDBTN_EN
    mouse_pulse(0, 0, 1'b0, 1'b0, 1'b1);
    rx_packet("mid_press", 4, 7'h40, 7'h00, 7'h00, 7'h20);
    expect_quiet("mid_press_quiet", 400);
    mouse_pulse(0, 0, 1'b0, 1'b0, 1'b0);
    rx_packet("mid_rel", 4, 7'h40, 7'h00, 7'h00, 7'h00);
    expect_quiet("mid_rel_quiet", 400);
`else
    mouse_pulse(0, 0, 1'b0, 1'b0, 1'b1);
    expect_quiet("mid_ignored", 400);
    mouse_pulse(0, 0, 1'b0, 1'b0, 1'b0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
`default_nettype wire
